wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning 1 selects round-robin tie-break and 0 selects fixed LSU priority.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, meaning the stall-cycle limit before forced abort; 0 disables the timeout.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rstn_i  input  1  reset, asynchronous and active-low.
REQ-005 Port if_bus  wb_bus_t.slave  interface  wishbone requester from the instruction fetch path (icache line fills).
REQ-006 Port lsu_bus  wb_bus_t.slave  interface  wishbone requester from the load/store unit.
REQ-007 Port mem_bus  wb_bus_t.master  interface  shared wishbone path to memory.
REQ-008 Port grant_o  output  2  one-hot current owner: bit0 IF, bit1 LSU, 00 idle.
REQ-009 Port timeout_o  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GNT_IF and GNT_LSU.
REQ-011 A request SHALL be cyc=1 and stb=1 on a requester bus.
REQ-012 In IDLE with one request, the FSM SHALL move to that requester's GNT state on the next edge; arbitration latency is 1 cycle.
REQ-013 In IDLE with both requesting: if ROUND_ROBIN=1, the requester not served last SHALL win; if ROUND_ROBIN=0, LSU SHALL win.
REQ-014 In GNT_x, mem_bus cyc, stb, we, sel, adr and write data SHALL equal requester x's, combinationally.
REQ-015 In GNT_x, requester x SHALL receive mem_bus ack, err and read data combinationally.
REQ-016 The non-granted requester SHALL see ack=0, err=0 and read data=0.
REQ-017 In IDLE, mem_bus cyc, stb and we SHALL be 0.
REQ-018 A grant SHALL be held while the owner keeps cyc=1, so multi-beat cache line fills are never interleaved.
REQ-019 When the owner drops cyc, the FSM SHALL leave GNT_x on that edge: to the other GNT state if the other is requesting, else to IDLE.
REQ-020 The last-served register SHALL update on every entry into a GNT state.
REQ-021 A stall counter SHALL count cycles in GNT_x with stb=1 and ack=0; it SHALL clear on ack, on err and on state change.
REQ-022 When the counter reaches TIMEOUT_CYCLES (non-zero), that cycle SHALL have owner err=1, mem_bus cyc=0 and timeout_o=1, and the FSM SHALL go to IDLE.
REQ-023 The counter SHALL saturate and never wrap; its width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.
REQ-024 A requester dropping cyc while its request is still in arbitration (IDLE cycle) SHALL lose the arbitration without any effect on mem_bus.
REQ-025 mem_bus err SHALL be forwarded to the owner unchanged; release still follows REQ-019.

Reset
REQ-026 On rstn_i=0, regardless of mid-transaction state, the FSM SHALL enter IDLE immediately.
REQ-027 On reset, the last-served register SHALL be IF, so the first tie goes to LSU; the counter SHALL be 0.
REQ-028 During reset, grant_o=00, timeout_o=0, mem_bus cyc=stb=0, and both requester ack and err SHALL be 0.

Structure
REQ-029 The arb_state_t enum and the IF and LSU index constants SHALL live in the shared core package.
REQ-030 The stall counter SHALL be one sub-module, wb_watchdog, with inputs clk, rstn_i, clr, en and output expired.
REQ-031 All muxing SHALL be combinational from registered state; the only flops are the state, last-served and counter flops.

Verification
REQ-032 IF only, 8-beat fill with ack each cycle: grant_o=01 one cycle after request, 8 acks to IF, IDLE the cycle after cyc drops.
REQ-033 Simultaneous first requests after reset (ROUND_ROBIN=1): LSU is granted first, then IF is granted the cycle after LSU releases; with ROUND_ROBIN=0, LSU wins 3 consecutive ties.
REQ-034 LSU requests mid IF burst (beat 3 of 8): the IF burst completes uninterrupted, and LSU is granted on the edge IF drops cyc.
REQ-035 With TIMEOUT_CYCLES=4, memory never acks: IF err=1 and timeout_o=1 on the 4th stall cycle, then IDLE; no err is seen by LSU.
REQ-036 rstn_i asserted mid LSU transfer: grant_o=00 and mem_bus cyc=0 immediately; after release, the next tie goes to LSU.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-requester wishbone arbiter: bus widths,
// arbitration state encoding and requester index constants.
package wb_arbiter_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_LSU = 2'd2
   } arb_state_t;

   localparam logic IF_IDX  = 1'b0;
   localparam logic LSU_IDX = 1'b1;

endpackage

// File: rtl/wb_bus_t.sv
// Classic wishbone bus bundle; the master drives the request side, the slave
// returns ack/err and read data.
interface wb_bus_t;
   import wb_arbiter_pkg::*;

   logic             cyc;
   logic             stb;
   logic             we;
   logic [WB_SW-1:0] sel;
   logic [WB_AW-1:0] adr;
   logic [WB_DW-1:0] dat_w;
   logic [WB_DW-1:0] dat_r;
   logic             ack;
   logic             err;

   modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);

endinterface

// File: rtl/wb_watchdog.sv
// Saturating stall counter; expired flags the stall cycle that reaches the limit.
module wb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rstn_i,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != SAT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // cnt_q holds the stalls already seen, so the current stall is the limit-th one
   assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt_q >= LAST);

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester wishbone arbiter (icache fill path vs. load/store unit) with
// burst-preserving grants and a stall watchdog that aborts hung transactions.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter bit          ROUND_ROBIN    = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rstn_i,
   wb_bus_t.slave     if_bus,
   wb_bus_t.slave     lsu_bus,
   wb_bus_t.master    mem_bus,
   output logic [1:0] grant_o,
   output logic       timeout_o
);

   arb_state_t state_q, state_d;
   logic       last_q, last_d;
   logic       if_req, lsu_req;
   logic       own_stb;
   logic       stall_en, stall_clr, expired;

   assign if_req  = if_bus.cyc & if_bus.stb;
   assign lsu_req = lsu_bus.cyc & lsu_bus.stb;

   always_comb begin
      own_stb = 1'b0;
      case (state_q)
         GNT_IF:  own_stb = if_bus.stb;
         GNT_LSU: own_stb = lsu_bus.stb;
         default: own_stb = 1'b0;
      endcase
   end

   assign stall_en  = own_stb & ~mem_bus.ack & ~mem_bus.err;
   assign stall_clr = mem_bus.ack | mem_bus.err | (state_d != state_q);

   wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk     (clk),
      .rstn_i  (rstn_i),
      .clr     (stall_clr),
      .en      (stall_en),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (if_req && lsu_req) begin
               state_d = (ROUND_ROBIN && (last_q == LSU_IDX)) ? GNT_IF : GNT_LSU;
            end else if (if_req) begin
               state_d = GNT_IF;
            end else if (lsu_req) begin
               state_d = GNT_LSU;
            end
         end
         // grant is held for the whole cycle so cache line fills stay contiguous
         GNT_IF: begin
            if (expired) begin
               state_d = IDLE;
            end else if (!if_bus.cyc) begin
               state_d = lsu_req ? GNT_LSU : IDLE;
            end
         end
         GNT_LSU: begin
            if (expired) begin
               state_d = IDLE;
            end else if (!lsu_bus.cyc) begin
               state_d = if_req ? GNT_IF : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         if (state_d == GNT_IF) begin
            last_d = IF_IDX;
         end else if (state_d == GNT_LSU) begin
            last_d = LSU_IDX;
         end
      end
   end

   always_comb begin
      mem_bus.cyc   = 1'b0;
      mem_bus.stb   = 1'b0;
      mem_bus.we    = 1'b0;
      mem_bus.sel   = '0;
      mem_bus.adr   = '0;
      mem_bus.dat_w = '0;
      if_bus.ack    = 1'b0;
      if_bus.err    = 1'b0;
      if_bus.dat_r  = '0;
      lsu_bus.ack   = 1'b0;
      lsu_bus.err   = 1'b0;
      lsu_bus.dat_r = '0;
      case (state_q)
         GNT_IF: begin
            mem_bus.cyc   = if_bus.cyc & ~expired;
            mem_bus.stb   = if_bus.stb & ~expired;
            mem_bus.we    = if_bus.we;
            mem_bus.sel   = if_bus.sel;
            mem_bus.adr   = if_bus.adr;
            mem_bus.dat_w = if_bus.dat_w;
            if_bus.ack    = mem_bus.ack;
            if_bus.err    = mem_bus.err | expired;
            if_bus.dat_r  = mem_bus.dat_r;
         end
         GNT_LSU: begin
            mem_bus.cyc   = lsu_bus.cyc & ~expired;
            mem_bus.stb   = lsu_bus.stb & ~expired;
            mem_bus.we    = lsu_bus.we;
            mem_bus.sel   = lsu_bus.sel;
            mem_bus.adr   = lsu_bus.adr;
            mem_bus.dat_w = lsu_bus.dat_w;
            lsu_bus.ack   = mem_bus.ack;
            lsu_bus.err   = mem_bus.err | expired;
            lsu_bus.dat_r = mem_bus.dat_r;
         end
         default: ;
      endcase
   end

   assign grant_o   = {state_q == GNT_LSU, state_q == GNT_IF};
   assign timeout_o = expired;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         last_q  <= IF_IDX;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 fixed LSU priority,
// both with a 4-cycle timeout, driven by independent randomized requesters.
module tb_wb_arbiter;

   localparam int TMO = 4;

   typedef struct {
      int               k;
      logic [1:0]       gnt;
      logic             tmo;
      logic             mcyc;
      logic             mstb;
      logic             mwe;
      logic             own;
      logic [3:0]       msel;
      logic [31:0]      madr;
      logic [31:0]      mdw;
      logic [1:0]       rack;
      logic [1:0]       rerr;
      logic [1:0][31:0] rdr;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // stimulus, indexed [instance][requester: 0 IF, 1 LSU]
   logic        rq_cyc [2][2];
   logic        rq_stb [2][2];
   logic        rq_we  [2][2];
   logic [3:0]  rq_sel [2][2];
   logic [31:0] rq_adr [2][2];
   logic [31:0] rq_dw  [2][2];
   logic        m_ack  [2];
   logic        m_err  [2];
   logic [31:0] m_dr   [2];

   logic        o_ack  [2][2];
   logic        o_err  [2][2];
   logic [31:0] o_dr   [2][2];
   logic        o_mcyc [2];
   logic        o_mstb [2];
   logic        o_mwe  [2];
   logic [3:0]  o_msel [2];
   logic [31:0] o_madr [2];
   logic [31:0] o_mdw  [2];
   logic [1:0]  o_gnt  [2];
   logic        o_tmo  [2];

   for (genvar g = 0; g < 2; g++) begin : g_inst
      wb_bus_t ifb ();
      wb_bus_t lsb ();
      wb_bus_t mb ();

      assign ifb.cyc   = rq_cyc[g][0];
      assign ifb.stb   = rq_stb[g][0];
      assign ifb.we    = rq_we[g][0];
      assign ifb.sel   = rq_sel[g][0];
      assign ifb.adr   = rq_adr[g][0];
      assign ifb.dat_w = rq_dw[g][0];
      assign lsb.cyc   = rq_cyc[g][1];
      assign lsb.stb   = rq_stb[g][1];
      assign lsb.we    = rq_we[g][1];
      assign lsb.sel   = rq_sel[g][1];
      assign lsb.adr   = rq_adr[g][1];
      assign lsb.dat_w = rq_dw[g][1];
      assign mb.ack    = m_ack[g];
      assign mb.err    = m_err[g];
      assign mb.dat_r  = m_dr[g];

      assign o_ack[g][0] = ifb.ack;
      assign o_err[g][0] = ifb.err;
      assign o_dr[g][0]  = ifb.dat_r;
      assign o_ack[g][1] = lsb.ack;
      assign o_err[g][1] = lsb.err;
      assign o_dr[g][1]  = lsb.dat_r;
      assign o_mcyc[g]   = mb.cyc;
      assign o_mstb[g]   = mb.stb;
      assign o_mwe[g]    = mb.we;
      assign o_msel[g]   = mb.sel;
      assign o_madr[g]   = mb.adr;
      assign o_mdw[g]    = mb.dat_w;

      wb_arbiter #(.ROUND_ROBIN(g == 0), .TIMEOUT_CYCLES(TMO)) dut (
         .clk       (clk),
         .rstn_i    (rstn),
         .if_bus    (ifb),
         .lsu_bus   (lsb),
         .mem_bus   (mb),
         .grant_o   (o_gnt[g]),
         .timeout_o (o_tmo[g])
      );
   end

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: owner -1 none / 0 IF / 1 LSU, last = requester served last
   int own   [2];
   int last  [2];
   int stall [2];

   // requester driver state
   bit act    [2][2];
   int beats  [2][2];
   int bursts [2][2];
   bit p_ack  [2][2];
   bit p_err  [2][2];

   int start_pct, ack_pct, err_pct, abort_pct, wait_pct;
   int blen [2];
   bit rst_req;

   function automatic void chk(string nm, int k, logic [95:0] act_v, logic [95:0] exp_v);
      n_cmp++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", nm, k, $time, act_v, exp_v);
      end
   endfunction

   exp_t me;
   always @(negedge clk) begin
      while (exp_q.size() != 0) begin
         me = exp_q.pop_front();
         chk("grant",   me.k, 96'(o_gnt[me.k]), 96'(me.gnt));
         chk("timeout", me.k, 96'(o_tmo[me.k]), 96'(me.tmo));
         chk("mem_cyc", me.k, 96'(o_mcyc[me.k]), 96'(me.mcyc));
         chk("mem_stb", me.k, 96'(o_mstb[me.k]), 96'(me.mstb));
         chk("mem_we",  me.k, 96'(o_mwe[me.k]), 96'(me.mwe));
         if (me.own) begin
            chk("mem_fwd", me.k, 96'({o_msel[me.k], o_madr[me.k], o_mdw[me.k]}),
                96'({me.msel, me.madr, me.mdw}));
         end
         chk("req_ack", me.k, 96'({o_ack[me.k][1], o_ack[me.k][0]}), 96'(me.rack));
         chk("req_err", me.k, 96'({o_err[me.k][1], o_err[me.k][0]}), 96'(me.rerr));
         chk("if_rdata",  me.k, 96'(o_dr[me.k][0]), 96'(me.rdr[0]));
         chk("lsu_rdata", me.k, 96'(o_dr[me.k][1]), 96'(me.rdr[1]));
      end
   end

   task automatic drive_req(int k, int r);
      if (act[k][r]) begin
         if (p_err[k][r]) begin
            act[k][r] = 1'b0;
         end else if (p_ack[k][r]) begin
            beats[k][r]--;
            if (beats[k][r] == 0) begin
               act[k][r] = 1'b0;
            end else begin
               rq_adr[k][r] = rq_adr[k][r] + 32'd4;
               rq_dw[k][r]  = $urandom;
               rq_we[k][r]  = 1'($urandom_range(1));
               rq_sel[k][r] = 4'($urandom_range(15));
            end
         end else if ((own[k] != r) && ($urandom_range(99) < abort_pct)) begin
            act[k][r] = 1'b0;
         end
      end else if ((bursts[k][r] > 0) && ($urandom_range(99) < start_pct)) begin
         act[k][r]    = 1'b1;
         bursts[k][r]--;
         beats[k][r]  = (blen[r] != 0) ? blen[r] : int'($urandom_range(1, 8));
         rq_adr[k][r] = $urandom & 32'hFFFF_FFE0;
         rq_dw[k][r]  = $urandom;
         rq_we[k][r]  = 1'($urandom_range(1));
         rq_sel[k][r] = 4'($urandom_range(15));
      end
      rq_cyc[k][r] = act[k][r];
      rq_stb[k][r] = act[k][r] && ($urandom_range(99) >= wait_pct);
   endtask

   task automatic model(int k);
      exp_t e;
      bit   req [2];
      int   x;
      int   nxt;
      bit   stalled;
      bit   tmo;
      e.k = k;  e.gnt = 2'b00; e.tmo = 1'b0; e.mcyc = 1'b0; e.mstb = 1'b0;
      e.mwe = 1'b0; e.own = 1'b0; e.msel = '0; e.madr = '0; e.mdw = '0;
      e.rack = 2'b00; e.rerr = 2'b00; e.rdr = '0;
      req[0] = rq_cyc[k][0] && rq_stb[k][0];
      req[1] = rq_cyc[k][1] && rq_stb[k][1];
      nxt = -1;
      if (!rstn) begin
         own[k] = -1; last[k] = 0; stall[k] = 0;
      end else if (own[k] < 0) begin
         if (req[0] && req[1]) begin
            // round-robin favours whoever was not served last; fixed priority is LSU
            nxt = ((k == 0) && (last[k] == 1)) ? 0 : 1;
         end else if (req[0]) begin
            nxt = 0;
         end else if (req[1]) begin
            nxt = 1;
         end
         stall[k] = 0;
      end else begin
         x       = own[k];
         e.gnt   = (x == 0) ? 2'b01 : 2'b10;
         stalled = rq_stb[k][x] && !m_ack[k] && !m_err[k];
         tmo     = stalled && (stall[k] + 1 >= TMO);
         e.tmo   = tmo;
         e.mcyc  = rq_cyc[k][x] && !tmo;
         e.mstb  = rq_stb[k][x] && !tmo;
         e.mwe   = rq_we[k][x];
         e.own   = 1'b1;
         e.msel  = rq_sel[k][x];
         e.madr  = rq_adr[k][x];
         e.mdw   = rq_dw[k][x];
         e.rack[x] = m_ack[k];
         e.rerr[x] = m_err[k] || tmo;
         e.rdr[x]  = m_dr[k];
         if (tmo) nxt = -1;
         else if (!rq_cyc[k][x]) nxt = req[1-x] ? 1 - x : -1;
         else nxt = x;
         if ((nxt != x) || m_ack[k] || m_err[k]) stall[k] = 0;
         else if (stalled && (stall[k] < TMO)) stall[k]++;
      end
      if (rstn) begin
         if ((nxt >= 0) && (nxt != own[k])) last[k] = nxt;
         own[k] = nxt;
      end
      p_ack[k][0] = e.rack[0]; p_ack[k][1] = e.rack[1];
      p_err[k][0] = e.rerr[0]; p_err[k][1] = e.rerr[1];
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rstn = !rst_req;
      for (int k = 0; k < 2; k++) begin
         if (rstn) begin
            for (int r = 0; r < 2; r++) drive_req(k, r);
         end
         m_ack[k] = ($urandom_range(99) < ack_pct);
         m_err[k] = !m_ack[k] && ($urandom_range(99) < err_pct);
         m_dr[k]  = $urandom;
      end
      for (int k = 0; k < 2; k++) model(k);
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic knobs(int st, int ak, int er, int ab, int wt, int l_if, int l_lsu);
      start_pct = st; ack_pct = ak; err_pct = er; abort_pct = ab; wait_pct = wt;
      blen[0] = l_if; blen[1] = l_lsu;
   endtask

   task automatic add_bursts(int n_if, int n_lsu);
      for (int k = 0; k < 2; k++) begin
         bursts[k][0] += n_if;
         bursts[k][1] += n_lsu;
      end
   endtask

   task automatic clear_drivers();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 2; r++) begin
            act[k][r] = 1'b0; bursts[k][r] = 0; beats[k][r] = 0;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         own[k] = -1; last[k] = 0; stall[k] = 0;
         m_ack[k] = 1'b0; m_err[k] = 1'b0; m_dr[k] = '0;
         for (int r = 0; r < 2; r++) begin
            rq_cyc[k][r] = 1'b0; rq_stb[k][r] = 1'b0; rq_we[k][r] = 1'b0;
            rq_sel[k][r] = '0; rq_adr[k][r] = '0; rq_dw[k][r] = '0;
            p_ack[k][r] = 1'b0; p_err[k][r] = 1'b0;
         end
      end
      clear_drivers();
      knobs(100, 100, 0, 0, 0, 8, 8);
      rst_req = 1'b1;
      run(3);
      rst_req = 1'b0;

      // single 8-beat instruction fill, acked every cycle
      add_bursts(1, 0);
      run(14);

      // simultaneous first requests straight out of reset, then two more ties
      rst_req = 1'b1;
      run(2);
      clear_drivers();
      rst_req = 1'b0;
      knobs(100, 100, 0, 0, 0, 4, 4);
      add_bursts(1, 1);
      run(14);
      repeat (2) begin
         knobs(100, 100, 0, 0, 0, 2, 2);
         add_bursts(1, 1);
         run(10);
      end

      // LSU arrives during beat 3 of an 8-beat fill
      knobs(100, 100, 0, 0, 0, 8, 4);
      add_bursts(1, 0);
      run(3);
      add_bursts(0, 1);
      run(18);

      // memory never acks: both requesters get aborted in turn
      knobs(100, 0, 0, 0, 0, 3, 2);
      add_bursts(1, 0);
      run(2);
      add_bursts(0, 1);
      run(16);

      // reset in the middle of an LSU transfer, then a tie
      knobs(100, 100, 0, 0, 0, 8, 8);
      add_bursts(0, 1);
      run(3);
      rst_req = 1'b1;
      run(2);
      clear_drivers();
      rst_req = 1'b0;
      knobs(100, 100, 0, 0, 0, 2, 2);
      add_bursts(1, 1);
      run(10);

      // randomized traffic with wait states, errors, aborts and timeouts
      knobs(40, 70, 3, 5, 10, 0, 0);
      add_bursts(1000, 1000);
      run(1500);

      @(negedge clk);
      #1;
      chk("scoreboard_drain", 0, 96'(exp_q.size()), 96'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
